div_ctrl: RTL and testbench

Sequencing controller for the iterative 33-cycle signed divider. It sits between the MIPS control unit and the divider: it latches operands and issues the one-cycle div_init pulse. It counts iterations, captures the results into the architectural HI/LO registers, and reports divide-by-zero. It stalls MFHI/MFLO/MTHI/MTLO and a new DIV while a division is in flight.

---
 rtl/mips_pkg.sv | 15 +
 rtl/div_ctrl_if.sv | 35 +++
 rtl/div_ctrl_hilo_regs.sv | 30 +++
 rtl/div_ctrl.sv | 116 +++++++++++
 tb/tb_div_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the divide sequencing controller and its HI/LO storage.
package mips_pkg;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = 33;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        EXC
    } div_state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// CPU-side request/response bundle of the divide controller: DIV issue, flush, MFxx/MTxx, HI/LO.
interface div_ctrl_if #(
    parameter int WIDTH = mips_pkg::WIDTH
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             abort;
    logic             mfhi_rd;
    logic             mflo_rd;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op_a, op_b, abort,
        output mfhi_rd, mflo_rd, mthi_we, mtlo_we, wdata,
        input  hi, lo, busy, stall, done, div_zero
    );

    modport slave (
        input  start, op_a, op_b, abort,
        input  mfhi_rd, mflo_rd, mthi_we, mtlo_we, wdata,
        output hi, lo, busy, stall, done, div_zero
    );

endinterface

// File: rtl/div_ctrl_hilo_regs.sv
// Architectural HI/LO register pair: MTHI/MTLO writes plus divider-result capture (capture wins).
module hilo_regs #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             cap_en,
    input  logic [WIDTH-1:0] cap_hi,
    input  logic [WIDTH-1:0] cap_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (cap_en) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else begin
            if (mthi_we) hi <= wdata;
            if (mtlo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the external iterative signed divider: operand latch, div_init pulse,
// iteration count, HI/LO writeback, divide-by-zero report and stall generation.
module div_ctrl #(
    parameter int WIDTH      = mips_pkg::WIDTH,
    parameter int DIV_CYCLES = mips_pkg::DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    div_ctrl_if.slave        bus,
    output logic             div_init,
    output logic [WIDTH-1:0] div_dividendo,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_mfhi,
    input  logic [WIDTH-1:0] div_mflo,
    input  logic             div_excessao
);

    import mips_pkg::*;

    localparam int               CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic             done_q;
    logic             div_zero_q;
    logic             in_idle;
    logic             req_any;
    logic             cap_en;
    logic             mthi_en;
    logic             mtlo_en;

    assign in_idle = (state == IDLE);
    assign req_any = bus.start | bus.mfhi_rd | bus.mflo_rd | bus.mthi_we | bus.mtlo_we;

    assign bus.busy     = ~in_idle;
    assign bus.stall    = ~in_idle & req_any;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

    // MT writes only land while idle; a stalled write is re-presented by the requester.
    assign mthi_en = in_idle & bus.mthi_we;
    assign mtlo_en = in_idle & bus.mtlo_we;
    assign cap_en  = (state == CAPTURE) & ~bus.abort;

    hilo_regs #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk     (clk),
        .reset   (reset),
        .mthi_we (mthi_en),
        .mtlo_we (mtlo_en),
        .wdata   (bus.wdata),
        .cap_en  (cap_en),
        .cap_hi  (div_mfhi),
        .cap_lo  (div_mflo),
        .hi      (bus.hi),
        .lo      (bus.lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            div_dividendo <= '0;
            div_divisor   <= '0;
            div_init      <= 1'b0;
            done_q        <= 1'b0;
            div_zero_q    <= 1'b0;
        end else begin
            div_init   <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            if (bus.abort && !in_idle) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            div_dividendo <= bus.op_a;
                            div_divisor   <= bus.op_b;
                            div_init      <= 1'b1;
                            state         <= START;
                        end
                    end
                    // The divider flags a zero divisor straight from the latched operands,
                    // so it is already visible while div_init is high.
                    START: begin
                        count <= CNT_ONE;
                        state <= div_excessao ? EXC : WAIT;
                    end
                    WAIT: begin
                        if (div_excessao && count == CNT_ONE) begin
                            state <= EXC;
                        end else if (count == CNT_LAST) begin
                            state <= CAPTURE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                    EXC: begin
                        div_zero_q <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a cycle-accurate behavioural divider alongside.
module tb_div_ctrl;

    localparam int W    = 32;
    localparam int NCYC = 33;

    logic         clk = 1'b0;
    logic         reset;
    logic         div_init;
    logic         div_excessao;
    logic [W-1:0] div_dividendo;
    logic [W-1:0] div_divisor;
    logic [W-1:0] div_mfhi = '0;
    logic [W-1:0] div_mflo = '0;

    div_ctrl_if #(.WIDTH(W)) bus ();

    div_ctrl #(
        .WIDTH      (W),
        .DIV_CYCLES (NCYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .div_init      (div_init),
        .div_dividendo (div_dividendo),
        .div_divisor   (div_divisor),
        .div_mfhi      (div_mfhi),
        .div_mflo      (div_mflo),
        .div_excessao  (div_excessao)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider: results appear only after the full iteration count, zero divisor flagged at once.
    logic signed [W-1:0] m_a = '0;
    logic signed [W-1:0] m_b = '0;
    int                  m_it = 0;
    assign div_excessao = (div_divisor == '0);
    always @(posedge clk) begin
        if (div_init) begin
            m_a      <= div_dividendo;
            m_b      <= div_divisor;
            m_it     <= 1;
            div_mfhi <= '0;
            div_mflo <= '0;
        end else if (m_it > 0 && m_it < NCYC) begin
            m_it <= m_it + 1;
            if (m_it == NCYC - 1 && m_b != 0) begin
                div_mflo <= m_a / m_b;
                div_mfhi <= m_a % m_b;
            end
        end
    end

    typedef struct {
        int           cyc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t q_init[$];
    exp_t q_done[$];
    exp_t q_zero[$];

    function automatic exp_t mk(input int c, input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t e;
        e.cyc = c;
        e.hi  = h;
        e.lo  = l;
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: pulse seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the matching expectation whenever the DUT pulses an output.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (div_init) begin
                if (q_init.size() == 0) unexpected("div_init");
                else begin
                    e = q_init.pop_front();
                    check("div_init cycle", cyc, e.cyc);
                end
            end
            if (bus.done) begin
                if (q_done.size() == 0) unexpected("done");
                else begin
                    e = q_done.pop_front();
                    check("done cycle", cyc, e.cyc);
                    check("done hi", bus.hi, e.hi);
                    check("done lo", bus.lo, e.lo);
                end
            end
            if (bus.div_zero) begin
                if (q_zero.size() == 0) unexpected("div_zero");
                else begin
                    e = q_zero.pop_front();
                    check("div_zero cycle", cyc, e.cyc);
                    check("div_zero hi kept", bus.hi, e.hi);
                    check("div_zero lo kept", bus.lo, e.lo);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t;
        int t2;
        int bad;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.abort   = 1'b0;
        bus.mfhi_rd = 1'b0;
        bus.mflo_rd = 1'b0;
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        bus.wdata   = '0;
        tick();
        tick();
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset dividendo", div_dividendo, 32'h0);
        check("reset divisor", div_divisor, 32'h0);
        checkb("reset busy", bus.busy, 1'b0);
        checkb("reset stall", bus.stall, 1'b0);
        checkb("reset done", bus.done, 1'b0);
        checkb("reset div_zero", bus.div_zero, 1'b0);
        checkb("reset div_init", div_init, 1'b0);
        reset = 1'b0;
        tick();

        // MTHI while idle
        bus.mthi_we = 1'b1;
        bus.wdata   = 32'hDEAD_BEEF;
        #1;
        checkb("mthi idle stall", bus.stall, 1'b0);
        tick();
        bus.mthi_we = 1'b0;
        check("mthi hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi lo untouched", bus.lo, 32'h0);

        // 100 / 7 with MFLO held from T+5 and a second DIV (-7 / 2) queued from T+10
        t = cyc;
        q_init.push_back(mk(t + 1, '0, '0));
        q_done.push_back(mk(t + 35, 32'd2, 32'd14));
        issue(32'd100, 32'd7);
        tick();
        bus.start = 1'b0;
        checkb("busy after start", bus.busy, 1'b1);
        check("latched dividend", div_dividendo, 32'd100);
        check("latched divisor", div_divisor, 32'd7);
        repeat (4) tick();
        bus.mflo_rd = 1'b1;
        bad = 0;
        for (int c = 5; c <= 34; c++) begin
            if (c == 10) issue(32'hFFFF_FFF9, 32'd2);
            #1;
            if (bus.stall !== 1'b1) bad++;
            tick();
        end
        check("stall cycles missing T+5..T+34", bad, 0);
        check("cycle at writeback", cyc, t + 35);
        checkb("stall released", bus.stall, 1'b0);
        checkb("busy low at done", bus.busy, 1'b0);
        check("mflo read lo", bus.lo, 32'd14);
        check("hi after 100/7", bus.hi, 32'd2);
        t2 = cyc;
        q_init.push_back(mk(t2 + 1, '0, '0));
        q_done.push_back(mk(t2 + 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
        tick();
        bus.start   = 1'b0;
        bus.mflo_rd = 1'b0;
        checkb("second div busy", bus.busy, 1'b1);
        repeat (34) tick();
        checkb("second div idle", bus.busy, 1'b0);
        check("hi after -7/2", bus.hi, 32'hFFFF_FFFF);
        check("lo after -7/2", bus.lo, 32'hFFFF_FFFD);

        // Divide by zero with HI/LO preloaded
        bus.mthi_we = 1'b1;
        bus.wdata   = 32'h11;
        tick();
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b1;
        bus.wdata   = 32'h22;
        tick();
        bus.mtlo_we = 1'b0;
        t = cyc;
        q_init.push_back(mk(t + 1, '0, '0));
        q_zero.push_back(mk(t + 3, 32'h11, 32'h22));
        issue(32'd5, 32'd0);
        tick();
        bus.start = 1'b0;
        tick();
        checkb("div0 busy T+2", bus.busy, 1'b1);
        tick();
        checkb("div0 busy T+3", bus.busy, 1'b0);
        repeat (40) tick();
        check("div0 hi kept", bus.hi, 32'h11);
        check("div0 lo kept", bus.lo, 32'h22);

        // Abort at T+20
        t = cyc;
        q_init.push_back(mk(t + 1, '0, '0));
        issue(32'd100, 32'd7);
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort cycle", cyc, t + 21);
        checkb("abort busy", bus.busy, 1'b0);
        repeat (40) tick();
        check("abort hi kept", bus.hi, 32'h11);
        check("abort lo kept", bus.lo, 32'h22);

        // Reset at T+10
        t = cyc;
        q_init.push_back(mk(t + 1, '0, '0));
        issue(32'd100, 32'd7);
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset cycle", cyc, t + 11);
        checkb("mid reset busy", bus.busy, 1'b0);
        checkb("mid reset done", bus.done, 1'b0);
        check("mid reset hi", bus.hi, 32'h0);
        check("mid reset lo", bus.lo, 32'h0);
        repeat (40) tick();

        check("pending div_init", q_init.size(), 0);
        check("pending done", q_done.size(), 0);
        check("pending div_zero", q_zero.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
